// File: rtl/dm_pkg.sv
// Shared definitions for the dm_bank data memory: access-size encodings,
// FSM state type and the alignment helper used at request accept.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dm_state_t;

    // Size 11 is reserved and always treated as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_bank_if.sv
// Request/response bus between the MEM stage (master) and dm_bank (slave).
interface dm_bank_if;
    logic [31:0] pc;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        resp_fault;
    logic        init_done;

    modport master (
        output pc, req_valid, req_we, req_size, req_sext, addr, wdata,
        input  req_ready, resp_valid, rdata, resp_fault, init_done
    );

    modport slave (
        input  pc, req_valid, req_we, req_size, req_sext, addr, wdata,
        output req_ready, resp_valid, rdata, resp_fault, init_done
    );
endinterface

// File: rtl/dm_lane.sv
// Little-endian lane logic: merges store data into a word and extracts/extends
// load data from a word, for byte, half and word sizes.
module dm_lane
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sext,
    output logic [31:0] merged,
    output logic [31:0] extracted
);
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_val = word[{offset, 3'b000} +: 8];
    assign half_val = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            SZ_WORD: merged = wdata;
            default: merged = word;
        endcase
    end

    always_comb begin
        extracted = '0;
        case (size)
            SZ_BYTE: extracted = {{24{sext & byte_val[7]}}, byte_val};
            SZ_HALF: extracted = {{16{sext & half_val[15]}}, half_val};
            SZ_WORD: extracted = word;
            default: extracted = '0;
        endcase
    end

endmodule

// File: rtl/dm_bank.sv
// Handshaked byte/half/word data memory with post-reset clear sweep and wait states.
// Optional store trace enabled by defining DM_TRACE_EN.
module dm_bank
    import dm_pkg::*;
#(
    parameter int DEPTH       = 3072,
    parameter int AW          = 12,
    parameter int WAIT_CYCLES = 0
) (
    input logic      clk,
    input logic      rst,
    dm_bank_if.slave bus
);
    localparam logic [AW-1:0]     LAST_IDX     = AW'(DEPTH - 1);
    localparam logic [31:0]       ADDR_LIMIT   = 32'(4 * DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_INIT    = WAIT_W'(WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(1);
    localparam dm_state_t         ACCEPT_STATE = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;

    dm_state_t         state, state_next;
    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     sweep_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              init_done_q;
    logic [31:0]       rdata_q, pend_rdata;
    logic              fault_q, pend_fault;

    logic              accept, req_fault, store_wr;
    logic [AW-1:0]     word_idx;
    logic [31:0]       cur_word, merged_word, load_word, result_rdata;

    assign word_idx     = bus.addr[AW+1:2];
    assign cur_word     = mem[word_idx];
    assign req_fault    = misaligned(bus.req_size, bus.addr[1:0]) || (bus.addr >= ADDR_LIMIT);
    assign accept       = bus.req_valid && bus.req_ready;
    assign store_wr     = accept && bus.req_we && !req_fault;
    assign result_rdata = (req_fault || bus.req_we) ? '0 : load_word;

    dm_lane u_lane (
        .word      (cur_word),
        .wdata     (bus.wdata),
        .size      (bus.req_size),
        .offset    (bus.addr[1:0]),
        .sext      (bus.req_sext),
        .merged    (merged_word),
        .extracted (load_word)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (sweep_idx == LAST_IDX) state_next = ST_IDLE;
            ST_IDLE: if (accept) state_next = ACCEPT_STATE;
            ST_WAIT: if (wait_cnt == WAIT_LAST) state_next = ST_RESP;
            ST_RESP: state_next = accept ? ACCEPT_STATE : ST_IDLE;
            default: state_next = ST_INIT;
        endcase
    end

    // Handshake outputs are forced low while reset is asserted so nothing is accepted.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        if (!rst) begin
            bus.req_ready  = (state == ST_IDLE) || ((state == ST_RESP) && (WAIT_CYCLES == 0));
            bus.resp_valid = (state == ST_RESP);
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.resp_fault = fault_q;
    assign bus.init_done  = init_done_q;

    // With wait states the result is parked until WAIT ends, so the visible
    // rdata/resp_fault only change when a new response is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_idx   <= '0;
            wait_cnt    <= '0;
            init_done_q <= 1'b0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            pend_rdata  <= '0;
            pend_fault  <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                if (sweep_idx == LAST_IDX) init_done_q <= 1'b1;
                else                       sweep_idx   <= sweep_idx + 1'b1;
            end
            if (accept) begin
                wait_cnt <= WAIT_INIT;
                if (WAIT_CYCLES == 0) begin
                    rdata_q <= result_rdata;
                    fault_q <= req_fault;
                end else begin
                    pend_rdata <= result_rdata;
                    pend_fault <= req_fault;
                end
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    rdata_q <= pend_rdata;
                    fault_q <= pend_fault;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == ST_INIT) begin
            mem[sweep_idx] <= '0;
        end else if (store_wr) begin
            mem[word_idx] <= merged_word;
`ifdef DM_TRACE_EN
            $display("@%08h: *%08h <= %08h", bus.pc, {bus.addr[31:2], 2'b00}, merged_word);
`endif
        end
    end

`ifndef DM_TRACE_EN
    logic unused_pc;
    assign unused_pc = ^bus.pc;
`endif

endmodule
